inst_mem_loader: RTL
====================

Name: inst_mem_loader

Overview:
Sequences loading a program into the instruction memory from the debug-unit UART byte stream. Assembles four received bytes into one 32-bit instruction and drives the memory write port (data, address, write enable) at consecutive addresses. Stops on the HALT instruction or on address overflow. Sits between the UART receiver and the instruction memory write port; the pipeline is held off until done_o.

Parameters:
NB_DATA, 32, instruction width in bits (fixed at 4 bytes)
NB_BYTE, 8, UART byte width
ADDRWIDTH, 7, instruction memory address width (128 words)
HALT_INST, 32'hFFFFFFFF, end-of-program marker

Ports:
clock_i  input  1  system clock (clock wizard output)
reset_i  input  1  asynchronous reset, active-low
locked_i  input  1  clock wizard locked; start_i ignored while low
start_i  input  1  one-cycle pulse: begin (or restart) a load
rx_data_i  input  NB_BYTE  received UART byte
rx_done_i  input  1  one-cycle strobe: rx_data_i valid
wr_data_o  output  NB_DATA  instruction to memory
wr_addr_o  output  ADDRWIDTH  memory write address
en_write_o  output  1  memory write enable
busy_o  output  1  load in progress
done_o  output  1  HALT written, program loaded
overflow_o  output  1  memory filled without HALT
count_o  output  ADDRWIDTH+1  words written in current load, including HALT

Behaviour:
- Reset (reset_i low, async): state IDLE; all outputs 0; byte counter, word register and address cleared. Memory contents are not touched. A partial word is discarded on reset mid-load.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR:
  - start_i=1 && locked_i=1 -> RECV next cycle.
  - Entry to RECV clears the byte counter, address, count_o, done_o and overflow_o, and sets busy_o=1.
  - rx_done_i is ignored in these states.
- RECV: each rx_done_i shifts word <= {word[23:0], rx_data_i}, so the first byte lands in [31:24] (big-endian, same order as the hex program file). Byte counter increments. The strobe carrying the 4th byte moves the FSM to WRITE on the next edge.
- WRITE: lasts exactly one cycle.
  - en_write_o=1, wr_data_o=word, wr_addr_o=current address. Latency is one cycle: 4th-byte strobe at edge N, en_write_o high during cycle N+1.
  - count_o increments at the end of the WRITE cycle.
  - If word==HALT_INST -> DONE.
  - Else if address==2^ADDRWIDTH-1 -> ERROR.
  - Else address+1 -> RECV.
  - A HALT at the last address goes to DONE, not ERROR.
  - An rx_done_i arriving during WRITE is captured as byte 0 of the next word (byte counter=1); no byte is lost.
- DONE: done_o=1, busy_o=0, en_write_o=0. Holds until reset or a new start_i.
- ERROR: overflow_o=1, busy_o=0, en_write_o=0. Holds until reset or start_i.
- start_i while in RECV/WRITE is ignored (no restart mid-load).
- en_write_o is never high outside WRITE. wr_data_o and wr_addr_o hold their last values outside WRITE.
- Address never wraps. count_o saturates at 2^ADDRWIDTH.

Test Plan:
- Reset, wait locked_i, start_i, send bytes 20,08,00,05 / FF,FF,FF,FF -> write 32'h20080005 @0, then 32'hFFFFFFFF @1; done_o=1, count_o=2, busy_o=0.
- start_i pulsed while locked_i=0 -> FSM stays IDLE, busy_o=0; same pulse after locked_i=1 -> busy_o=1 next cycle.
- 3 bytes sent, then reset_i low mid-word -> all outputs 0 immediately; new load writes the first word at addr 0 with the correct value (no stale bytes).
- 128 non-HALT words -> writes to addr 0..127, overflow_o=1, done_o=0, count_o=128. Repeat with HALT as the 128th word -> done_o=1, overflow_o=0.
- rx_done_i strobes on consecutive cycles (4th byte of word k, then 1st byte of word k+1 during WRITE) -> both words written correctly at consecutive addresses.
- After done_o, a second start_i with a 1-word HALT program -> done_o drops, then rises again; count_o=1; write occurs at addr 0.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Program loader: packs UART bytes into 32-bit words and writes
// them to instruction memory until HALT or the memory is full.
module inst_mem_loader #(
  parameter int NB_DATA   = 32,
  parameter int NB_BYTE   = 8,
  parameter int ADDRWIDTH = 7,
  parameter logic [NB_DATA-1:0] HALT_INST = 32'hFFFFFFFF
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 locked_i,
  input  logic                 start_i,
  input  logic [NB_BYTE-1:0]   rx_data_i,
  input  logic                 rx_done_i,
  output logic [NB_DATA-1:0]   wr_data_o,
  output logic [ADDRWIDTH-1:0] wr_addr_o,
  output logic                 en_write_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o,
  output logic [ADDRWIDTH:0]   count_o
);

  localparam int NBYTES = NB_DATA / NB_BYTE;
  localparam int BCW    = $clog2(NBYTES);

  localparam logic [BCW-1:0] LAST_BYTE =
    BCW'(NBYTES - 1);
  localparam logic [ADDRWIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDRWIDTH:0] COUNT_MAX =
    (ADDRWIDTH+1)'(2 ** ADDRWIDTH);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t state;
  state_t next_state;

  logic [BCW-1:0]       byte_cnt;
  logic [NB_DATA-1:0]   word;
  logic [NB_DATA-1:0]   shifted;
  logic [ADDRWIDTH-1:0] addr;
  logic                 launch;
  logic                 take_byte;
  logic                 word_full;

  assign shifted = {word[NB_DATA-NB_BYTE-1:0], rx_data_i};

  // A byte arriving during WRITE belongs to the next word.
  assign take_byte = rx_done_i &&
    (state == RECV || state == WRITE);

  assign word_full = state == RECV && rx_done_i &&
    byte_cnt == LAST_BYTE;

  assign launch = start_i && locked_i &&
    (state == IDLE || state == DONE || state == ERROR);

  // State register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE, ERROR: begin
        if (launch) next_state = RECV;
      end
      RECV: begin
        if (word_full) next_state = WRITE;
      end
      WRITE: begin
        if (wr_data_o == HALT_INST)
          next_state = DONE;
        else if (addr == ADDR_MAX)
          next_state = ERROR;
        else
          next_state = RECV;
      end
      default: next_state = IDLE;
    endcase
  end

  // Status and write-enable decode from the current state.
  always_comb begin
    en_write_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    overflow_o = 1'b0;
    unique case (state)
      RECV:  busy_o = 1'b1;
      WRITE: begin
        busy_o     = 1'b1;
        en_write_o = 1'b1;
      end
      DONE:  done_o     = 1'b1;
      ERROR: overflow_o = 1'b1;
      default: ;
    endcase
  end

  // Byte assembly, write port latches, address and word count.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      byte_cnt  <= '0;
      word      <= '0;
      addr      <= '0;
      count_o   <= '0;
      wr_data_o <= '0;
      wr_addr_o <= '0;
    end else if (launch) begin
      byte_cnt <= '0;
      addr     <= '0;
      count_o  <= '0;
    end else begin
      if (take_byte) begin
        word     <= shifted;
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (word_full) begin
        wr_data_o <= shifted;
        wr_addr_o <= addr;
      end
      if (state == WRITE) begin
        if (count_o != COUNT_MAX)
          count_o <= count_o + 1'b1;
        if (next_state == RECV)
          addr <= addr + 1'b1;
      end
    end
  end

endmodule
